// File: rtl/fpga_pkg.sv
// rtl/fpga_pkg.sv - shared constants and types for the RFID front-end block
// Holds the configuration word bit positions, carrier divider values,
// SSP timing constants and the SSP engine state type.
package fpga_pkg;

  localparam int CONF_LO_FREQ = 7;
  localparam int CONF_CARRIER = 6;
  localparam int CONF_SEL125  = 5;

  // Carrier half-period minus one, in pck0 cycles (24 MHz / 192 and / 178).
  localparam logic [7:0] DIV_125 = 8'd95;
  localparam logic [7:0] DIV_134 = 8'd88;

  // ssp_clk half-period in pck0 cycles; one bit lasts twice this.
  localparam int          SSP_HALF     = 4;
  localparam logic [2:0]  SSP_HALF_W   = 3'(SSP_HALF);
  localparam logic [2:0]  SSP_SUB_LAST = 3'(2 * SSP_HALF - 1);

  typedef enum logic {
    SSP_IDLE = 1'b0,
    SSP_SEND = 1'b1
  } ssp_state_t;

endpackage

// File: rtl/spi_conf_rx.sv
// rtl/spi_conf_rx.sv - SPI-style configuration receiver
// Ports:
//   clk, rst        : pck0 and synchronous active-high reset
//   spck, mosi, ncs : asynchronous SPI link from the MCU (MSB first)
//   conf_word       : last 8 bits shifted in before ncs rose
//   conf_load       : high on the cycle conf_word is being updated
module spi_conf_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic [7:0] conf_word,
  output logic       conf_load
);

  logic [1:0] spck_sync;
  logic [1:0] mosi_sync;
  logic [1:0] ncs_sync;
  logic       spck_prev;
  logic       ncs_prev;
  logic [7:0] shift_reg;
  logic       spck_rise;

  // mosi and spck go through equal-depth synchronizers, so the synced data
  // bit is aligned with the synced clock edge that samples it.
  assign spck_rise = spck_sync[1] & ~spck_prev & ~ncs_sync[1];
  assign conf_load = ncs_sync[1] & ~ncs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      spck_sync <= 2'b00;
      mosi_sync <= 2'b00;
      // ncs idles high; resetting its history high avoids a false load on release.
      ncs_sync  <= 2'b11;
      spck_prev <= 1'b0;
      ncs_prev  <= 1'b1;
      shift_reg <= 8'h00;
      conf_word <= 8'h00;
    end else begin
      spck_sync <= {spck_sync[0], spck};
      mosi_sync <= {mosi_sync[0], mosi};
      ncs_sync  <= {ncs_sync[0], ncs};
      spck_prev <= spck_sync[1];
      ncs_prev  <= ncs_sync[1];
      if (spck_rise) begin
        shift_reg <= {shift_reg[6:0], mosi_sync[1]};
      end
      if (conf_load) begin
        conf_word <= shift_reg;
      end
    end
  end

endmodule

// File: rtl/fpga.sv
// rtl/fpga.sv - RFID front-end top: config receiver, LF carrier, ADC capture, SSP sender
// Ports:
//   pck0, rst                  : 24 MHz clock, synchronous active-high reset
//   spck, mosi, ncs, miso      : configuration link from the MCU (miso tied 0)
//   ck_1356meg, ck_1356megb    : 13.56 MHz clocks (only the inverted one gates pwr_hi)
//   pwr_lo, pwr_hi, pwr_oe1..4 : antenna drive and driver enables
//   adc_d, adc_clk, adc_noe    : ADC sample, conversion clock, output enable
//   ssp_frame, ssp_din, ssp_clk, ssp_dout : synchronous serial link to the MCU
module fpga
  import fpga_pkg::*;
(
  input  logic       pck0,
  input  logic       rst,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  input  logic       ck_1356meg,
  input  logic       ck_1356megb,
  output logic       pwr_lo,
  output logic       pwr_hi,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  input  logic [7:0] adc_d,
  output logic       adc_clk,
  output logic       adc_noe,
  output logic       ssp_frame,
  output logic       ssp_din,
  input  logic       ssp_dout,
  output logic       ssp_clk
);

  logic [7:0] conf_word;
  logic       conf_load;
  logic       lo_freq;
  logic       carrier_on;
  logic       sel125;

  spi_conf_rx u_spi (
    .clk       (pck0),
    .rst       (rst),
    .spck      (spck),
    .mosi      (mosi),
    .ncs       (ncs),
    .conf_word (conf_word),
    .conf_load (conf_load)
  );

  assign lo_freq    = conf_word[CONF_LO_FREQ];
  assign carrier_on = conf_word[CONF_CARRIER];
  assign sel125     = conf_word[CONF_SEL125];

  logic unused_inputs;
  assign unused_inputs = ^{ck_1356meg, ssp_dout, conf_word[4:0]};

  // Carrier generator
  logic [7:0] div;
  logic [7:0] cnt;
  logic       phase;
  logic       at_div;
  logic       capture;

  assign div     = sel125 ? DIV_125 : DIV_134;
  assign at_div  = (cnt == div);
  // The edge where phase is about to drop 1->0 is the sample point.
  assign capture = lo_freq & phase & at_div & ~conf_load;

  always_ff @(posedge pck0) begin
    if (rst || conf_load || !lo_freq) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (at_div) begin
      cnt   <= 8'd0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 8'd1;
    end
  end

  // SSP engine
  ssp_state_t state, state_next;
  logic [2:0] bit_idx, bit_next;
  logic [2:0] sub_cnt, sub_next;
  logic [7:0] ssp_sh;

  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    sub_next   = sub_cnt;
    if (conf_load) begin
      state_next = SSP_IDLE;
      bit_next   = 3'd0;
      sub_next   = 3'd0;
    end else if (capture) begin
      // A capture mid-frame simply restarts the frame.
      state_next = SSP_SEND;
      bit_next   = 3'd7;
      sub_next   = 3'd0;
    end else if (state == SSP_SEND) begin
      if (sub_cnt == SSP_SUB_LAST) begin
        sub_next = 3'd0;
        if (bit_idx == 3'd0) begin
          state_next = SSP_IDLE;
        end else begin
          bit_next = bit_idx - 3'd1;
        end
      end else begin
        sub_next = sub_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      state   <= SSP_IDLE;
      bit_idx <= 3'd0;
      sub_cnt <= 3'd0;
      ssp_sh  <= 8'h00;
    end else begin
      state   <= state_next;
      bit_idx <= bit_next;
      sub_cnt <= sub_next;
      if (capture) begin
        ssp_sh <= adc_d;
      end
    end
  end

  // Registered outputs, one cycle behind the state they decode.
  always_ff @(posedge pck0) begin
    if (rst) begin
      pwr_lo    <= 1'b0;
      adc_clk   <= 1'b0;
      adc_noe   <= 1'b1;
      ssp_clk   <= 1'b0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
    end else begin
      pwr_lo    <= phase & carrier_on & lo_freq;
      adc_clk   <= lo_freq & phase;
      adc_noe   <= 1'b0;
      ssp_clk   <= (state == SSP_SEND) & (sub_cnt >= SSP_HALF_W);
      ssp_din   <= (state == SSP_SEND) & ssp_sh[bit_idx];
      ssp_frame <= (state == SSP_SEND) & (bit_idx == 3'd7);
    end
  end

  assign pwr_hi  = ck_1356megb & carrier_on & ~lo_freq;
  assign pwr_oe1 = 1'b0;
  assign pwr_oe2 = 1'b0;
  assign pwr_oe3 = 1'b0;
  assign pwr_oe4 = 1'b0;
  assign miso    = 1'b0;

endmodule

// File: tb/tb_fpga.sv
// tb/tb_fpga.sv - directed self-checking bench for fpga
module tb_fpga;

  logic       pck0 = 1'b0;
  logic       rst;
  logic       spck;
  logic       mosi;
  logic       ncs;
  logic       miso;
  logic       ck_1356meg;
  logic       ck_1356megb;
  logic       pwr_lo;
  logic       pwr_hi;
  logic       pwr_oe1;
  logic       pwr_oe2;
  logic       pwr_oe3;
  logic       pwr_oe4;
  logic [7:0] adc_d;
  logic       adc_clk;
  logic       adc_noe;
  logic       ssp_frame;
  logic       ssp_din;
  logic       ssp_dout;
  logic       ssp_clk;

  int checks = 0;
  int errors = 0;

  fpga dut (
    .pck0        (pck0),
    .rst         (rst),
    .spck        (spck),
    .mosi        (mosi),
    .ncs         (ncs),
    .miso        (miso),
    .ck_1356meg  (ck_1356meg),
    .ck_1356megb (ck_1356megb),
    .pwr_lo      (pwr_lo),
    .pwr_hi      (pwr_hi),
    .pwr_oe1     (pwr_oe1),
    .pwr_oe2     (pwr_oe2),
    .pwr_oe3     (pwr_oe3),
    .pwr_oe4     (pwr_oe4),
    .adc_d       (adc_d),
    .adc_clk     (adc_clk),
    .adc_noe     (adc_noe),
    .ssp_frame   (ssp_frame),
    .ssp_din     (ssp_din),
    .ssp_dout    (ssp_dout),
    .ssp_clk     (ssp_clk)
  );

  always #5 pck0 = ~pck0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pck0);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    tick(4);
    spck = 1'b1;
    tick(4);
    spck = 1'b0;
    tick(4);
  endtask

  task automatic spi_word(input logic [7:0] w, input int lead);
    ncs = 1'b0;
    tick(4);
    for (int i = 0; i < lead; i++) spi_bit(1'b0);
    for (int i = 7; i >= 0; i--) spi_bit(w[i]);
    tick(4);
    ncs = 1'b1;
    tick(6);
  endtask

  // Measures one full pwr_lo period starting at a rising edge.
  task automatic measure(output int hi, output int lo);
    int guard;
    hi = 0;
    lo = 0;
    guard = 0;
    while (pwr_lo !== 1'b0 && guard < 1000) begin tick(1); guard++; end
    while (pwr_lo !== 1'b1 && guard < 1000) begin tick(1); guard++; end
    while (pwr_lo === 1'b1 && guard < 1000) begin hi++; tick(1); guard++; end
    while (pwr_lo === 1'b0 && guard < 1000) begin lo++; tick(1); guard++; end
  endtask

  initial begin
    int hi, lo, guard;
    int frame_cnt, clk_rises, lo_high, clk_high, adc_rises;
    logic frame_bad, clk_bad, din_bad, idle_bad, prev_clk, prev_din, prev_adc;
    logic [7:0] din_byte;

    rst = 1'b1; spck = 1'b0; mosi = 1'b0; ncs = 1'b1;
    ck_1356meg = 1'b0; ck_1356megb = 1'b1; adc_d = 8'h00; ssp_dout = 1'b0;
    tick(4);
    check("reset_conf", dut.conf_word, 32'h00);
    check("reset_pwr_lo", pwr_lo, 32'd0);
    check("reset_pwr_hi", pwr_hi, 32'd0);
    check("reset_adc_clk", adc_clk, 32'd0);
    check("reset_ssp", {ssp_frame, ssp_din, ssp_clk}, 32'd0);
    check("reset_adc_noe", adc_noe, 32'd1);
    check("reset_oe_miso", {miso, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4}, 32'd0);
    rst = 1'b0;
    tick(2);
    check("run_adc_noe", adc_noe, 32'd0);

    // LF 125 kHz, carrier on, with extra leading bits.
    spi_word(8'hE0, 9);
    check("conf_e0", dut.conf_word, 32'hE0);
    check("e0_pwr_hi", pwr_hi, 32'd0);
    measure(hi, lo);
    check("e0_hi", hi, 32'd96);
    check("e0_lo", lo, 32'd96);

    // Capture of 0x9D at the next pwr_lo fall and its SSP frame.
    adc_d = 8'h9D;
    guard = 0;
    while (pwr_lo !== 1'b1 && guard < 1000) begin tick(1); guard++; end
    while (pwr_lo === 1'b1 && guard < 1000) begin tick(1); guard++; end
    check("ssp_frame_at_fall", ssp_frame, 32'd1);
    frame_cnt = 0; clk_rises = 0; din_byte = 8'h00;
    frame_bad = 1'b0; clk_bad = 1'b0; din_bad = 1'b0; idle_bad = 1'b0;
    prev_clk = 1'b0; prev_din = ssp_din;
    for (int j = 0; j < 72; j++) begin
      if (j == 1) adc_d = 8'h00;
      if (ssp_frame === 1'b1) begin
        frame_cnt++;
        if (j >= 8) frame_bad = 1'b1;
      end
      if (j % 8 == 0 && j < 64) din_byte = {din_byte[6:0], ssp_din};
      if (j % 8 != 0 && ssp_din !== prev_din) din_bad = 1'b1;
      if (ssp_clk === 1'b1 && prev_clk === 1'b0) begin
        clk_rises++;
        if (j % 8 != 4) clk_bad = 1'b1;
      end
      if (j >= 64 && {ssp_frame, ssp_din, ssp_clk} !== 3'b000) idle_bad = 1'b1;
      prev_clk = ssp_clk;
      prev_din = ssp_din;
      tick(1);
    end
    check("ssp_frame_cycles", frame_cnt, 32'd8);
    check("ssp_frame_position", frame_bad, 32'd0);
    check("ssp_din_byte", din_byte, 32'h9D);
    check("ssp_din_stable", din_bad, 32'd0);
    check("ssp_clk_rises", clk_rises, 32'd8);
    check("ssp_clk_phase", clk_bad, 32'd0);
    check("ssp_idle_after", idle_bad, 32'd0);

    // LF 134 kHz.
    spi_word(8'hC0, 9);
    check("conf_c0", dut.conf_word, 32'hC0);
    measure(hi, lo);
    check("c0_hi", hi, 32'd89);
    check("c0_period", hi + lo, 32'd178);

    // LF, carrier off: ADC clock and SSP still run.
    spi_word(8'hA0, 9);
    check("conf_a0", dut.conf_word, 32'hA0);
    lo_high = 0; adc_rises = 0; frame_cnt = 0; prev_adc = adc_clk;
    for (int j = 0; j < 350; j++) begin
      if (pwr_lo === 1'b1) lo_high++;
      if (adc_clk === 1'b1 && prev_adc === 1'b0) adc_rises++;
      if (ssp_frame === 1'b1) frame_cnt++;
      prev_adc = adc_clk;
      tick(1);
    end
    check("a0_pwr_lo_off", lo_high, 32'd0);
    check("a0_adc_rises", adc_rises, 32'd2);
    check("a0_frame_cycles", frame_cnt, 32'd8);

    // HF, carrier on.
    spi_word(8'h40, 9);
    check("conf_40", dut.conf_word, 32'h40);
    ck_1356megb = 1'b1; #1;
    check("hf_pwr_hi_1", pwr_hi, 32'd1);
    ck_1356megb = 1'b0; #1;
    check("hf_pwr_hi_0", pwr_hi, 32'd0);
    ck_1356megb = 1'b1; #1;
    check("hf_pwr_hi_1b", pwr_hi, 32'd1);
    clk_high = 0;
    for (int j = 0; j < 200; j++) begin
      if ((pwr_lo | adc_clk | ssp_clk) === 1'b1) clk_high++;
      tick(1);
    end
    check("hf_lf_outputs_quiet", clk_high, 32'd0);

    // spck activity while deselected must not change the configuration.
    for (int i = 0; i < 8; i++) spi_bit(1'b1);
    check("ncs_high_no_change", dut.conf_word, 32'h40);

    // Exactly 8 bits, then reset mid-operation.
    spi_word(8'hE0, 0);
    check("conf_e0_nolead", dut.conf_word, 32'hE0);
    tick(150);
    rst = 1'b1;
    tick(2);
    check("midrst_conf", dut.conf_word, 32'h00);
    check("midrst_adc_noe", adc_noe, 32'd1);
    check("midrst_outs", {pwr_lo, adc_clk, ssp_frame, ssp_din, ssp_clk}, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
